// File: rtl/panel_switch_conditioner.sv
// Front-panel switch conditioner: 2-FF sync + debounce per switch, rising-edge pulses with
// CLEAR > HALT > RUN and STEPI > STEPM priority, optional STEPM auto-repeat, power-on CLEAR.
module panel_switch_conditioner #(
    parameter int DEBOUNCE      = 16,
    parameter int CNT_W         = 16,
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 1000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SW_RUN,
    input  logic       SW_HALT,
    input  logic       SW_STEPM,
    input  logic       SW_STEPI,
    input  logic       SW_CLEAR,
    output logic       RUN,
    output logic       HALT,
    output logic       STEPM,
    output logic       STEPI,
    output logic       CLEAR,
    output logic [4:0] SW_LEVEL
);
    localparam int NSW = 5;
    localparam int I_RUN = 0, I_HALT = 1, I_STEPM = 2, I_STEPI = 3, I_CLEAR = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REPEAT} rep_state_t;

    logic [NSW-1:0]            raw;
    logic [NSW-1:0]            sync1_q, sync1_d;
    logic [NSW-1:0]            sync2_q, sync2_d;
    logic [NSW-1:0]            level_q, level_d;
    logic [NSW-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NSW-1:0]            pulse_q, pulse_d;
    logic [NSW-1:0]            rise;
    logic                      por_q, por_d;
    rep_state_t                state_q, state_d;
    logic [CNT_W-1:0]          rcnt_q, rcnt_d;
    logic                      clr, rep_exit, rep_fire;

    assign raw = {SW_CLEAR, SW_STEPI, SW_STEPM, SW_HALT, SW_RUN};

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        for (int i = 0; i < NSW; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        rise = level_d & ~level_q;
    end

    // Repeat pulses are gated on the previous STEPM so the output always drops between pulses.
    always_comb begin
        clr      = rise[I_CLEAR] | por_q;
        rep_exit = clr | (level_q[I_STEPM] & ~level_d[I_STEPM]);
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        rep_fire = 1'b0;
        por_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rcnt_d = '0;
            end
            ST_WAIT: begin
                if (rep_exit) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
                    rep_fire = ~pulse_q[I_STEPM];
                    state_d  = ST_REPEAT;
                    rcnt_d   = '0;
                end else begin
                    rcnt_d = rcnt_q + CNT_W'(1);
                end
            end
            ST_REPEAT: begin
                if (rep_exit) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
                    rep_fire = ~pulse_q[I_STEPM];
                    rcnt_d   = '0;
                end else begin
                    rcnt_d = rcnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end
        endcase

        pulse_d          = '0;
        pulse_d[I_CLEAR] = clr;
        pulse_d[I_HALT]  = rise[I_HALT] & ~clr;
        pulse_d[I_RUN]   = rise[I_RUN] & ~rise[I_HALT] & ~clr;
        pulse_d[I_STEPI] = rise[I_STEPI] & ~clr;
        pulse_d[I_STEPM] = (rise[I_STEPM] | rep_fire) & ~rise[I_STEPI] & ~clr;

        // Only an initial pulse that survived arbitration arms the repeat timer.
        if (REPEAT_DELAY != 0 && state_q == ST_IDLE && pulse_d[I_STEPM]) begin
            state_d = ST_WAIT;
            rcnt_d  = '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            pulse_q <= '0;
            por_q   <= 1'b1;
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            por_q   <= por_d;
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign RUN      = pulse_q[I_RUN];
    assign HALT     = pulse_q[I_HALT];
    assign STEPM    = pulse_q[I_STEPM];
    assign STEPI    = pulse_q[I_STEPI];
    assign CLEAR    = pulse_q[I_CLEAR];
    assign SW_LEVEL = level_q;

endmodule

// File: tb/tb_panel_switch_conditioner.sv
// Directed bench for panel_switch_conditioner: DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
module tb_panel_switch_conditioner;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       SW_RUN, SW_HALT, SW_STEPM, SW_STEPI, SW_CLEAR;
    logic       RUN, HALT, STEPM, STEPI, CLEAR;
    logic [4:0] SW_LEVEL;
    logic [4:0] pulses;
    logic [4:0] acc;
    int         n_chk  = 0;
    int         n_pass = 0;

    panel_switch_conditioner #(
        .DEBOUNCE      (4),
        .CNT_W         (16),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (8)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .SW_RUN   (SW_RUN),
        .SW_HALT  (SW_HALT),
        .SW_STEPM (SW_STEPM),
        .SW_STEPI (SW_STEPI),
        .SW_CLEAR (SW_CLEAR),
        .RUN      (RUN),
        .HALT     (HALT),
        .STEPM    (STEPM),
        .STEPI    (STEPI),
        .CLEAR    (CLEAR),
        .SW_LEVEL (SW_LEVEL)
    );

    always #5 CLK = ~CLK;

    assign pulses = {CLEAR, STEPI, STEPM, HALT, RUN};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET    = 1'b1;
        SW_RUN   = 1'b0;
        SW_HALT  = 1'b0;
        SW_STEPM = 1'b0;
        SW_STEPI = 1'b0;
        SW_CLEAR = 1'b0;
        repeat (3) tick();
        check("reset_pulses", 32'(pulses), 32'h0);
        check("reset_level", 32'(SW_LEVEL), 32'h0);

        // Power-on CLEAR on the first edge after release, then silence.
        RESET = 1'b0;
        tick();
        check("por_clear", 32'(pulses), 32'h10);
        tick();
        check("por_clear_off", 32'(pulses), 32'h0);
        acc = '0;
        for (int i = 0; i < 100; i++) begin
            tick();
            acc |= pulses;
        end
        check("idle_quiet", 32'(acc), 32'h0);

        // RUN: first sampled at E0 (t=0), pulse after E0+5 only.
        SW_RUN = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            check($sformatf("run_pulse_t%0d", t), 32'(pulses), (t == 5) ? 32'h01 : 32'h0);
            check($sformatf("run_level_t%0d", t), 32'(SW_LEVEL[0]), (t >= 5) ? 32'h1 : 32'h0);
        end
        SW_RUN = 1'b0;
        acc = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            acc |= pulses;
        end
        check("run_release_quiet", 32'(acc), 32'h0);
        check("run_release_level", 32'(SW_LEVEL), 32'h0);

        // HALT bouncing every 2 cycles never qualifies.
        acc = '0;
        for (int i = 0; i < 40; i++) begin
            SW_HALT = ((i / 2) % 2 == 0);
            tick();
            acc |= pulses;
        end
        check("halt_bounce_quiet", 32'(acc), 32'h0);
        SW_HALT = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            check($sformatf("halt_pulse_t%0d", t), 32'(pulses), (t == 5) ? 32'h02 : 32'h0);
        end
        SW_HALT = 1'b0;
        repeat (12) tick();

        // RUN+HALT together -> HALT only.
        SW_RUN  = 1'b1;
        SW_HALT = 1'b1;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            acc |= pulses;
        end
        check("run_halt_arb", 32'(acc), 32'h02);
        check("run_halt_level", 32'(SW_LEVEL), 32'h03);
        SW_RUN  = 1'b0;
        SW_HALT = 1'b0;
        repeat (12) tick();

        // RUN+HALT+CLEAR together -> CLEAR only.
        SW_RUN   = 1'b1;
        SW_HALT  = 1'b1;
        SW_CLEAR = 1'b1;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            acc |= pulses;
        end
        check("clear_arb", 32'(acc), 32'h10);
        SW_RUN   = 1'b0;
        SW_HALT  = 1'b0;
        SW_CLEAR = 1'b0;
        repeat (12) tick();

        // STEPM+STEPI together -> STEPI only.
        SW_STEPM = 1'b1;
        SW_STEPI = 1'b1;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            acc |= pulses;
        end
        check("step_arb", 32'(acc), 32'h08);
        SW_STEPM = 1'b0;
        SW_STEPI = 1'b0;
        acc = '0;
        for (int i = 0; i < 30; i++) begin
            tick();
            acc |= pulses;
        end
        check("step_arb_no_repeat", 32'(acc), 32'h0);

        // Auto-repeat: P0 at t=5, then P0+20, +28, ... +60; release after P0+60.
        SW_STEPM = 1'b1;
        for (int t = 0; t <= 100; t++) begin
            logic exp_m;
            tick();
            exp_m = (t >= 5) && (t <= 65) &&
                    ((t - 5) == 0 || ((t - 5) >= 20 && ((t - 5 - 20) % 8) == 0));
            check($sformatf("repeat_t%0d", t), 32'(pulses), exp_m ? 32'h04 : 32'h0);
            if (t == 65) SW_STEPM = 1'b0;
        end

        // Reset during WAIT: async clear, one CLEAR pulse, fresh debounce window.
        SW_STEPM = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (t == 5) check("pre_reset_stepm", 32'(pulses), 32'h04);
        end
        RESET = 1'b1;
        #1;
        check("async_reset_pulses", 32'(pulses), 32'h0);
        check("async_reset_level", 32'(SW_LEVEL), 32'h0);
        tick();
        check("in_reset_pulses", 32'(pulses), 32'h0);
        RESET = 1'b0;
        for (int t = 0; t < 29; t++) begin
            logic [4:0] exp_p;
            tick();
            exp_p = 5'h0;
            if (t == 0) exp_p = 5'h10;
            if (t == 5 || t == 25) exp_p = 5'h04;
            check($sformatf("post_reset_t%0d", t), 32'(pulses), 32'(exp_p));
        end
        SW_STEPM = 1'b0;
        repeat (10) tick();
        check("final_level", 32'(SW_LEVEL), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/panel_switch_conditioner.md
Name: panel_switch_conditioner

Overview:
Front-panel input stage directly upstream of the CPU sequencer. Synchronises and debounces the raw RUN, HALT, STEP-MICRO, STEP-INSTR and CLEAR panel switches in the PDP clock domain. Emits clean single-cycle pulses (RUN, HALT, STEPM, STEPI, CLEAR) that the sequencer samples on the same CLK. Adds priority arbitration, STEPM auto-repeat and a power-on CLEAR pulse.

Parameters:
DEBOUNCE, 16, consecutive CLK samples a synchronised switch must differ from its debounced level before that level flips (>=1)
CNT_W, 16, width of the debounce and repeat counters
REPEAT_DELAY, 0, CLK cycles from the initial STEPM pulse to the first auto-repeat pulse; 0 disables auto-repeat
REPEAT_PERIOD, 1000, CLK cycles between subsequent auto-repeat pulses (>=1)

Ports:
CLK  in  1  PDP clock, the sequencer's clock; all logic on the rising edge
RESET  in  1  asynchronous, active-high reset
SW_RUN  in  1  raw RUN switch, asynchronous, bouncy
SW_HALT  in  1  raw HALT switch
SW_STEPM  in  1  raw single-microstep switch
SW_STEPI  in  1  raw single-instruction switch
SW_CLEAR  in  1  raw panel CLEAR switch
RUN  out  1  one-cycle pulse to sequencer
HALT  out  1  one-cycle pulse to sequencer
STEPM  out  1  one-cycle pulse to sequencer
STEPI  out  1  one-cycle pulse to sequencer
CLEAR  out  1  one-cycle pulse to sequencer CLEAR
SW_LEVEL  out  5  debounced levels {CLEAR,STEPI,STEPM,HALT,RUN}, for panel lamps

Behaviour:
- Reset (async, while RESET=1): all sync FFs, debounced levels, counters and pulse outputs = 0. Power-on flag = 1.
- Power-on clear: on the first CLK edge after RESET deasserts, CLEAR=1 for exactly one cycle and the flag clears. Subsequent resets re-arm the flag.
- Per-switch channel, identical for all five:
  - 2-FF synchroniser.
  - Debounce counter: increments each edge while sync2 != debounced level, and clears on any edge where they agree.
  - When the counter would reach DEBOUNCE, the level flips and the counter clears.
- Latency: raw high first sampled at edge E0 -> sync2 high after E0+1 -> level flips at edge E0+1+DEBOUNCE. The raw pulse is registered on that same edge, giving output high from E0+1+DEBOUNCE to E0+2+DEBOUNCE.
- Any glitch shorter than DEBOUNCE sampled cycles produces no level change and no pulse.
- Only 0->1 level transitions generate pulses. Release produces nothing.
- Arbitration, applied when registering pulses in a given cycle:
  - CLEAR pulse (panel or power-on) suppresses RUN, HALT, STEPM and STEPI in that cycle.
  - RUN and HALT together -> HALT only.
  - STEPM and STEPI together -> STEPI only.
  - Suppressed pulses are dropped, not deferred.
- Auto-repeat (REPEAT_DELAY != 0, STEPM only):
  - States IDLE / WAIT / REPEAT.
  - IDLE -> WAIT on the initial STEPM pulse; the repeat counter loads 0.
  - WAIT: after REPEAT_DELAY cycles, emit a STEPM pulse and go to REPEAT.
  - REPEAT: emit a pulse every REPEAT_PERIOD cycles.
  - STEPM level falling, or any CLEAR pulse -> IDLE immediately; no further pulses.
  - Repeat pulses are subject to the same arbitration as the initial pulse.
- Every pulse is at most one cycle wide, and STEPM always returns low between pulses. The sequencer's wait-for-release capture on STEPM therefore always completes.
- SW_LEVEL reflects the debounced levels directly (registered, no extra latency).
- RESET mid-debounce or mid-repeat: all state is lost, with no pulse on release except the power-on CLEAR.

Test Plan:
- DEBOUNCE=4; deassert RESET, hold all switches low -> CLEAR high exactly one cycle after the first edge; no other pulses over 100 cycles.
- DEBOUNCE=4; SW_RUN rises and is first sampled at edge E0 -> RUN high from E0+5 to E0+6 only; SW_LEVEL[0]=1 from E0+5; release gives no pulse.
- DEBOUNCE=4; SW_HALT toggles every 2 cycles for 40 cycles, then stays high -> no HALT pulse during toggling; a single HALT pulse 6 edges after the last rising sample.
- SW_RUN and SW_HALT rise on the same cycle -> HALT pulse only, RUN stays 0. Repeat with SW_CLEAR also rising -> CLEAR only.
- REPEAT_DELAY=20, REPEAT_PERIOD=8, DEBOUNCE=4; hold SW_STEPM high for 60 cycles after the initial pulse at P0 -> STEPM pulses at P0, P0+20, P0+28, P0+36, P0+44, P0+52, P0+60. No pulses after the level falls.
- Assert RESET for 1 cycle during the WAIT state of the previous case -> all outputs 0 asynchronously; one CLEAR pulse after release; initial STEPM pulse reissued only after a fresh DEBOUNCE window.
